// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: steps FETCH/DECODE/EXEC/MEM/WB over a shared
// single-port memory and emits per-state datapath strobes for the current opcode.
// Also keeps a wrapping count of retired instructions.
module multicycle_sequencer #(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned B_ADD  = 4,
    parameter int unsigned B_AND  = 25,
    parameter int unsigned B_MOVL = 12,
    parameter int unsigned B_MOVS = 13,
    parameter int unsigned B_JA   = 14,
    parameter int unsigned B_CMP  = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [63:0]      opc,
    input  logic             flag_above,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             ir_write,
    output logic [1:0]       alu_op,
    output logic             flags_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        I_ADD, I_AND, I_MOVL, I_MOVS, I_JA, I_CMP
    } ins_t;

    localparam logic [63:0] OH_ADD  = 64'd1 << B_ADD;
    localparam logic [63:0] OH_AND  = 64'd1 << B_AND;
    localparam logic [63:0] OH_MOVL = 64'd1 << B_MOVL;
    localparam logic [63:0] OH_MOVS = 64'd1 << B_MOVS;
    localparam logic [63:0] OH_JA   = 64'd1 << B_JA;
    localparam logic [63:0] OH_CMP  = 64'd1 << B_CMP;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    ins_t             ins_q, ins_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire_s;

    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic             addr_sel_q, addr_sel_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic             flags_write_q, flags_write_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_to_reg_q, mem_to_reg_d;
    logic             halted_q, halted_d;

    // Next-state, instruction class, sticky illegal flag and retire counter
    always_comb begin
        state_d   = state_q;
        ins_d     = ins_q;
        illegal_d = illegal_q;
        retire_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
                else     state_d = S_IDLE;
            end
            S_FETCH: begin
                if (mem_ack) state_d = S_DECODE;
                else         state_d = S_FETCH;
            end
            S_DECODE: begin
                // Exactly one supported bit is legal; zero or multi-hot halts
                state_d = S_EXEC;
                if      (opc == OH_ADD)  ins_d = I_ADD;
                else if (opc == OH_AND)  ins_d = I_AND;
                else if (opc == OH_MOVL) ins_d = I_MOVL;
                else if (opc == OH_MOVS) ins_d = I_MOVS;
                else if (opc == OH_JA)   ins_d = I_JA;
                else if (opc == OH_CMP)  ins_d = I_CMP;
                else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXEC: begin
                case (ins_q)
                    I_ADD, I_AND:   state_d = S_WB;
                    I_MOVL, I_MOVS: state_d = S_MEM;
                    default:        retire_s = 1'b1;
                endcase
            end
            S_MEM: begin
                if (mem_ack) begin
                    if (ins_q == I_MOVS) retire_s = 1'b1;
                    else                 state_d  = S_WB;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB:    retire_s = 1'b1;
            S_HALT:  state_d  = S_HALT;
            default: state_d  = S_IDLE;
        endcase

        // Retire edge: count it and re-check run before the next fetch
        if (retire_s) begin
            retired_d = retired_q + CNT_ONE;
            if (run) state_d = S_FETCH;
            else     state_d = S_IDLE;
        end else begin
            retired_d = retired_q;
        end
    end

    // Registered strobes decoded from the state being entered
    always_comb begin
        mem_req_d     = 1'b0;
        mem_we_d      = 1'b0;
        addr_sel_d    = 1'b0;
        alu_op_d      = 2'b00;
        flags_write_d = 1'b0;
        reg_write_d   = 1'b0;
        mem_to_reg_d  = 1'b0;
        halted_d      = 1'b0;
        case (state_d)
            S_FETCH: mem_req_d = 1'b1;
            S_EXEC: begin
                case (ins_d)
                    I_AND:   alu_op_d = 2'b01;
                    I_CMP: begin
                        alu_op_d      = 2'b10;
                        flags_write_d = 1'b1;
                    end
                    default: alu_op_d = 2'b00;
                endcase
            end
            S_MEM: begin
                mem_req_d  = 1'b1;
                addr_sel_d = 1'b1;
                mem_we_d   = (ins_d == I_MOVS);
            end
            S_WB: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = (ins_d == I_MOVL);
                if (ins_d == I_AND) alu_op_d = 2'b01;
                else                alu_op_d = 2'b00;
            end
            S_HALT:  halted_d = 1'b1;
            default: halted_d = 1'b0;
        endcase
    end

    // Sequencer state and registered outputs; reset forces everything idle at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ins_q         <= I_ADD;
            illegal_q     <= 1'b0;
            retired_q     <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            addr_sel_q    <= 1'b0;
            alu_op_q      <= 2'b00;
            flags_write_q <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ins_q         <= ins_d;
            illegal_q     <= illegal_d;
            retired_q     <= retired_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            addr_sel_q    <= addr_sel_d;
            alu_op_q      <= alu_op_d;
            flags_write_q <= flags_write_d;
            reg_write_q   <= reg_write_d;
            mem_to_reg_q  <= mem_to_reg_d;
            halted_q      <= halted_d;
        end
    end

    // Ack-driven fetch strobes and the conditional jump must act in the same cycle
    assign ir_write    = (state_q == S_FETCH) && mem_ack;
    assign pc_inc      = (state_q == S_FETCH) && mem_ack;
    assign pc_load     = (state_q == S_EXEC) && (ins_q == I_JA) && flag_above;

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign addr_sel    = addr_sel_q;
    assign alu_op      = alu_op_q;
    assign flags_write = flags_write_q;
    assign reg_write   = reg_write_q;
    assign mem_to_reg  = mem_to_reg_q;
    assign illegal     = illegal_q;
    assign halted      = halted_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: table of instructions with expected latency and
// strobe summaries, scoreboarded per instruction, plus hand-written corner sequences.
module tb_multicycle_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic [63:0]   opc = 64'd0;
    logic          flag_above = 1'b0;
    logic          mem_ack = 1'b0;
    logic          mem_req, mem_we, addr_sel, pc_inc, pc_load, ir_write;
    logic [1:0]    alu_op;
    logic          flags_write, reg_write, mem_to_reg, illegal, halted;
    logic [CW-1:0] retired;

    multicycle_sequencer #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .opc(opc), .flag_above(flag_above),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .pc_inc(pc_inc), .pc_load(pc_load), .ir_write(ir_write), .alu_op(alu_op),
        .flags_write(flags_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] opc;
        logic        flag;
        int          wf;
        int          wm;
        int          lat;
        int          rw;
        logic        we;
        logic        m2r;
        logic        pcl;
        int          fw;
        logic [1:0]  alu;
    } vec_t;

    typedef struct {
        int            lat;
        int            rw;
        logic          we;
        logic          m2r;
        logic          pcl;
        int            fw;
        logic [1:0]    alu;
        logic [CW-1:0] ret;
    } exp_t;

    vec_t          vecs [8];
    exp_t          sb [$];
    int            n_checks = 0;
    int            n_fail = 0;
    logic [CW-1:0] model_ret = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [12:0] all_outs();
        return {mem_req, mem_we, addr_sel, pc_inc, pc_load, ir_write, alu_op,
                flags_write, reg_write, mem_to_reg, illegal, halted};
    endfunction

    // Runs one instruction from the current negedge until the retire edge
    task automatic run_instr(input vec_t v, input logic run_val);
        exp_t          e;
        logic [CW-1:0] base;
        bit            started = 0;
        bit            done = 0;
        int            waited = 0;
        int            cyc = 0, rw = 0, fw = 0, irw = 0, pci = 0;
        logic          we = 1'b0, m2r = 1'b0, pcl = 1'b0;
        logic [1:0]    alu = 2'b00;
        opc        = v.opc;
        flag_above = v.flag;
        run        = run_val;
        model_ret  = model_ret + 4'd1;
        e = '{v.lat, v.rw, v.we, v.m2r, v.pcl, v.fw, v.alu, model_ret};
        sb.push_back(e);
        base = retired;
        for (int k = 0; k < 60; k++) begin
            if (retired !== base) begin
                done = 1;
                break;
            end
            if (!started && mem_req && !addr_sel) started = 1;
            if (started) cyc++;
            if (mem_req) begin
                if (waited >= (addr_sel ? v.wm : v.wf)) begin
                    mem_ack = 1'b1;
                    waited = 0;
                end else begin
                    mem_ack = 1'b0;
                    waited++;
                end
            end else begin
                mem_ack = 1'b0;
            end
            #1;
            rw  += int'(reg_write);
            fw  += int'(flags_write);
            irw += int'(ir_write);
            pci += int'(pc_inc);
            we  |= mem_we;
            m2r |= mem_to_reg;
            pcl |= pc_load;
            alu |= alu_op;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        check("retire_seen", 64'(done), 64'd1);
        e = sb.pop_front();
        check("latency", 64'(cyc), 64'(e.lat));
        check("reg_write_cycles", 64'(rw), 64'(e.rw));
        check("flags_write_cycles", 64'(fw), 64'(e.fw));
        check("ir_write_cycles", 64'(irw), 64'd1);
        check("pc_inc_cycles", 64'(pci), 64'd1);
        check("mem_we", 64'(we), 64'(e.we));
        check("mem_to_reg", 64'(m2r), 64'(e.m2r));
        check("pc_load", 64'(pcl), 64'(e.pcl));
        check("alu_op", 64'(alu), 64'(e.alu));
        check("retired", 64'(retired), 64'(e.ret));
    endtask

    initial begin
        logic [63:0] o;
        logic [12:0] acc;
        int          cyc;
        bit          found;
        vec_t        cmpv;

        //            opc            flg wf wm lat rw we m2r pcl fw alu
        vecs[0] = '{64'd1 << 4,  1'b0, 0, 0, 4, 1, 1'b0, 1'b0, 1'b0, 0, 2'b00};
        vecs[1] = '{64'd1 << 25, 1'b0, 0, 0, 4, 1, 1'b0, 1'b0, 1'b0, 0, 2'b01};
        vecs[2] = '{64'd1 << 12, 1'b0, 2, 2, 9, 1, 1'b0, 1'b1, 1'b0, 0, 2'b00};
        vecs[3] = '{64'd1 << 13, 1'b0, 0, 1, 5, 0, 1'b1, 1'b0, 1'b0, 0, 2'b00};
        vecs[4] = '{64'd1 << 14, 1'b1, 0, 0, 3, 0, 1'b0, 1'b0, 1'b1, 0, 2'b00};
        vecs[5] = '{64'd1 << 14, 1'b0, 0, 0, 3, 0, 1'b0, 1'b0, 1'b0, 0, 2'b00};
        vecs[6] = '{64'd1 << 59, 1'b0, 0, 0, 3, 0, 1'b0, 1'b0, 1'b0, 1, 2'b10};
        vecs[7] = '{64'd1 << 4,  1'b0, 1, 0, 5, 1, 1'b0, 1'b0, 1'b0, 0, 2'b00};
        cmpv    = vecs[6];

        // Reset state, then idle with run low
        repeat (2) @(negedge clk);
        check("reset_outputs", 64'(all_outs()), 64'd0);
        check("reset_retired", 64'(retired), 64'd0);
        rst = 1'b0;
        acc = '0;
        repeat (3) begin
            @(negedge clk);
            acc |= all_outs();
        end
        check("idle_while_run_low", 64'(acc), 64'd0);

        // Table-driven instruction mix
        for (int i = 0; i < 8; i++) run_instr(vecs[i], 1'b1);

        // Counter wrap: eight more CMPs reach 16 retires; the last drops run
        for (int i = 0; i < 8; i++) run_instr(cmpv, (i == 7) ? 1'b0 : 1'b1);
        check("wrap_to_zero", 64'(retired), 64'd0);
        acc = '0;
        repeat (5) begin
            #1 acc |= all_outs();
            @(negedge clk);
        end
        check("idle_after_run_drop", 64'(acc), 64'd0);

        // Multi-hot opcode: illegal, halted, no further memory traffic
        o = (64'd1 << 4) | (64'd1 << 25);
        opc = o;
        run = 1'b1;
        cyc = 0;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (halted) begin
                found = 1;
                break;
            end
            if (mem_req || cyc > 0) cyc++;
            mem_ack = mem_req;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        check("halt_reached", 64'(found), 64'd1);
        check("halt_latency", 64'(cyc), 64'd2);
        check("illegal_sticky", 64'(illegal), 64'd1);
        acc = '0;
        repeat (10) begin
            acc[0] |= mem_req;
            acc[1] |= ~halted;
            acc[2] |= reg_write | ir_write;
            @(negedge clk);
        end
        check("halt_quiet", 64'(acc), 64'd0);
        check("halt_no_retire", 64'(retired), 64'd0);
        run = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_clears_halt", 64'({illegal, halted}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Store interrupted by reset while the data access is pending
        opc = 64'd1 << 13;
        run = 1'b1;
        found = 0;
        for (int k = 0; k < 20; k++) begin
            if (mem_req && addr_sel) begin
                found = 1;
                break;
            end
            mem_ack = mem_req;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        check("mem_phase_reached", 64'(found), 64'd1);
        check("store_we", 64'(mem_we), 64'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", 64'(all_outs()), 64'd0);
        check("async_rst_retired", 64'(retired), 64'd0);
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        acc = '0;
        repeat (3) begin
            @(negedge clk);
            acc |= all_outs();
        end
        check("idle_after_rst", 64'(acc), 64'd0);
        check("no_partial_retire", 64'(retired), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
